// File: rtl/pwm_duty_seq.sv
// Duty-cycle sequencer: steps a RAM table of compare values into the PWM counter's cmp,
// updating only on counter wrap edges. Define PWM_DUTY_SEQ_LOOP_EN to repeat the sequence until stop.
module pwm_duty_seq #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          rst_n,
  input  logic          clk50m,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] len,
  input  logic [7:0]    reps,
  input  logic          en,
  input  logic [W-1:0]  per,
  input  logic [W-1:0]  cnt_in,
  output logic [W-1:0]  cmp,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  tbl_mem [2**AW];
  logic [W-1:0]  nxt_q;
  logic          nxt_vld_q, nxt_vld_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [W-1:0]  cmp_q, cmp_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    rep_q, rep_d;
  logic [AW-1:0] len_q, len_d;
  logic [7:0]    reps_q, reps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          stop_pend_q, stop_pend_d;

  logic [W-1:0]  per_m1;
  logic [AW-1:0] idx_inc;
  logic          wrap;
  logic          stop_any;
  logic          addr_load;

  // Same W-bit wrap test as the counter, so cmp changes on the edge cnt returns to 0.
  assign per_m1   = per - W'(1);
  assign wrap     = en && (cnt_in >= per_m1);
  assign stop_any = stop_pend_q || stop;
  assign idx_inc  = idx_q + AW'(1);

  // Table RAM; nxt_q is its registered read port, so a colliding write returns old data.
  always_ff @(posedge clk50m) begin
    if (wr_en) tbl_mem[wr_addr] <= wr_data;
    nxt_q <= tbl_mem[rd_addr_q];
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cmp_d       = cmp_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    len_d       = len_q;
    reps_d      = reps_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    addr_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_ARM;
          len_d     = len;
          reps_d    = reps;
          rd_addr_d = '0;
          addr_load = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_ARM, S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (wrap) begin
          if (stop_any) begin
            state_d     = S_IDLE;
            cmp_d       = '0;
            idx_d       = '0;
            rep_d       = '0;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else if (state_q == S_ARM) begin
            if (nxt_vld_q) begin
              state_d   = S_RUN;
              cmp_d     = nxt_q;
              idx_d     = '0;
              rep_d     = '0;
              rd_addr_d = (len_q == '0) ? '0 : AW'(1);
              addr_load = 1'b1;
            end
          end else if (rep_q < reps_q) begin
            rep_d = rep_q + 8'd1;
          end else if (idx_q < len_q) begin
            cmp_d     = nxt_q;
            idx_d     = idx_inc;
            rep_d     = '0;
            rd_addr_d = (idx_inc == len_q) ? '0 : idx_inc + AW'(1);
            addr_load = 1'b1;
          end else begin
`ifdef PWM_DUTY_SEQ_LOOP_EN
            cmp_d     = nxt_q;
            idx_d     = '0;
            rep_d     = '0;
            rd_addr_d = (len_q == '0) ? '0 : AW'(1);
            addr_load = 1'b1;
`else
            state_d = S_IDLE;
            cmp_d   = '0;
            idx_d   = '0;
            rep_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Prefetch is stale for one cycle after any read-address load.
    nxt_vld_d = !addr_load;
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nxt_vld_q   <= 1'b0;
      rd_addr_q   <= '0;
      cmp_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nxt_vld_q   <= nxt_vld_d;
      rd_addr_q   <= rd_addr_d;
      cmp_q       <= cmp_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      len_q       <= len_d;
      reps_q      <= reps_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign cmp  = cmp_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/pwm_duty_seq.md
# pwm_duty_seq

Duty-cycle sequencer directly upstream of the PWM counter: holds a table of compare values in a small on-chip RAM and steps through it, driving the counter's `cmp` input. Each table entry is held for a programmable number of PWM periods. `cmp` only ever changes on the clock edge where the counter wraps to 0, so every period is glitch-free. Count-up operation (`down = 0`) only.

## Interface
- `W`, 8: compare/period width; must match the PWM counter's `W`.
- `AW`, 4: table address width; depth is 2**AW entries.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk50m`  in  1  clock.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  W  table write data (compare value).
- `start`  in  1  single-cycle pulse; begins a sequence when idle.
- `stop`  in  1  single-cycle pulse; ends the sequence at the next wrap.
- `len`  in  AW  index of the last table entry (sequence is entries 0..len); sampled on start.
- `reps`  in  8  each entry is held for reps+1 periods; sampled on start.
- `en`  in  1  the same enable that drives the PWM counter.
- `per`  in  W  the same period that drives the PWM counter.
- `cnt_in`  in  W  the PWM counter's `cnt` output.
- `cmp`  out  W  compare value to the PWM counter.
- `idx`  out  AW  index of the entry currently on `cmp`.
- `busy`  out  1  high while a sequence is active.
- `done`  out  1  single-cycle pulse on natural completion.

## Operation
- Table: 2**AW × W RAM. Synchronous write. Synchronous read with 1-cycle latency. On a same-address read/write collision the read returns the old data. Writes are allowed at any time.
- Wrap event: `wrap = en && (cnt_in >= per - 1)`. This is evaluated in W-bit arithmetic, identical to the counter's own wrap test, so it coincides with the edge where `cnt` returns to 0.
- Prefetch register `nxt` holds the entry for the next step. A `nxt_vld` flag clears whenever the read address changes and sets 1 cycle later.
- Read address after each step: `idx + 1`. When `idx == len`, the read address is 0.
- States:
  - IDLE: `cmp` = 0, `busy` = 0.
  - ARM: waiting for the first valid wrap.
  - RUN: stepping through the table.
- IDLE → ARM on `start`. Action: latch `len`/`reps`, set read address to 0, `busy` ← 1.
- ARM → RUN on `wrap && nxt_vld`. Action: `cmp` ← `nxt`, `idx` ← 0, repeat count ← 0, prefetch the next entry. A wrap with `nxt_vld` = 0 is skipped (state stays ARM).
- RUN, on each wrap:
  - If repeat count < `reps`: increment the repeat count; `cmp` is unchanged.
  - Otherwise, if `idx < len`: `cmp` ← `nxt`, `idx` ← `idx + 1`, repeat count ← 0.
  - Otherwise (`idx == len`): end of sequence, behaviour per Configuration.
- `stop` while busy sets `stop_pend`. At the next wrap (in ARM or RUN): `cmp` ← 0, `idx` ← 0, go to IDLE, `done` stays 0.
- `stop` and end of sequence on the same wrap: stop wins, no `done`.
- `start` while busy is ignored. `start` and `stop` in the same cycle while idle: stop wins, the sequence does not start.
- `en` = 0 produces no wrap events, so the whole sequence freezes.
- `per` < 2 is not supported; wraps then occur closer together than the prefetch latency.

## Timing
- Reset values: `cmp` = 0, `idx` = 0, `busy` = 0, `done` = 0, state IDLE, `stop_pend` = 0, `nxt_vld` = 0.
- `busy` rises 1 cycle after `start` is sampled. It falls on the same edge where `cmp` returns to 0.
- `cmp` and `idx` update only on wrap edges, so the first cycle of every period already uses the new value.
- `done` is high for 1 cycle, aligned with `cmp` ← 0.
- A sequence of `len + 1` entries lasts exactly `(len + 1) × (reps + 1)` periods after the first accepted wrap.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronously). Table contents are undefined after reset.

## Configuration
- `PWM_DUTY_SEQ_LOOP_EN` defined: at the end of the sequence, `cmp` ← `nxt` (entry 0) and `idx` ← 0. The sequence repeats indefinitely until `stop`; `done` never pulses.
- Macro undefined: at the end of the sequence, `cmp` ← 0, `idx` ← 0, go to IDLE, `done` pulses.

## Test plan
- Basic run: W = 8, `per` = 10, table {2, 5, 8}, `len` = 2, `reps` = 0, `en` = 1, start. Required: `cmp` is 2, 5, 8 for exactly 10 cycles each, then 0. `done` pulses on the third wrap after the first accepted wrap; `busy` falls on the same edge.
- Repeats: same table with `reps` = 2. Required: each value is held for 30 cycles, and `idx` increments every 30 cycles.
- Stop mid-run: stop issued 4 cycles into entry 1. Required: `cmp` stays 5 until the wrap, then 0. No `done`; `busy` = 0 after that edge.
- `en` gating: drop `en` for 50 cycles during entry 0. Required: `cmp` stays 2 and `idx` stays 0; the sequence resumes unchanged when `en` returns.
- Live write and reset: write 7 to entry 2 while entry 0 is active. Required: the third value is 7. Then assert `rst_n` = 0 mid-run; required: `cmp` = 0 and `busy` = 0 immediately.
- Loop (`PWM_DUTY_SEQ_LOOP_EN`): basic run setup. Required: sequence 2, 5, 8, 2, 5 … with no `done` pulse; stop ends it at the next wrap.
